// File: rtl/ds1124_sweep_ctrl.sv
// Sweep sequencer for ds1124_driver: writes each delay code from start to stop,
// optionally verifies it by readback, settles, then offers the point to a consumer.
module ds1124_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 1000,
  parameter bit VERIFY        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] start_delay,
  input  logic [7:0] stop_delay,
  input  logic [7:0] step,
  output logic       point_valid,
  input  logic       point_ack,
  output logic [7:0] cur_delay,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] delay_value,
  output logic       en,
  output logic       read_delay,
  input  logic       ready,
  input  logic [7:0] current_delay,
  input  logic       read_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WR_WAIT, S_READ, S_RD_WAIT, S_SETTLE, S_POINT, S_NEXT
  } state_t;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  // Next code, saturating at stop (and therefore never wrapping past 255).
  function automatic logic [7:0] next_code(input logic [7:0] cur,
                                           input logic [7:0] inc,
                                           input logic [7:0] lim);
    logic [8:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum > {1'b0, lim}) return lim;
    return sum[7:0];
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       cur_q, cur_d;
  logic [7:0]       stop_q, stop_d;
  logic [7:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             skip_q;
  logic             pv_q, pv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             en_q, en_d;
  logic             rd_q, rd_d;
  logic             abort_any;

  assign abort_any = abort | abort_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    stop_d  = stop_q;
    step_d  = step_q;
    cnt_d   = '0;
    error_d = error_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    rd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_delay > stop_delay) begin
            error_d = 1'b1;
          end else begin
            cur_d   = start_delay;
            stop_d  = stop_delay;
            step_d  = (step == 8'd0) ? 8'd1 : step;
            error_d = 1'b0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (ready) begin
          en_d    = 1'b1;
          state_d = S_WR_WAIT;
        end
      end
      // Ready is stale while the pulse is out and the cycle after it.
      S_WR_WAIT: begin
        if (!en_q && !skip_q && ready) begin
          if (abort_any)   state_d = S_IDLE;
          else if (VERIFY) state_d = S_READ;
          else             state_d = S_SETTLE;
        end
      end
      S_READ: begin
        if (ready) begin
          rd_d    = 1'b1;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!rd_q && read_valid) begin
          if (current_delay != cur_q) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else if (abort_any) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (abort_any)                 state_d = S_IDLE;
        else if (cnt_q == SETTLE_LAST) state_d = S_POINT;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      S_POINT: begin
        if (abort_any)      state_d = S_IDLE;
        else if (point_ack) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (abort_any) begin
          state_d = S_IDLE;
        end else if (cur_q == stop_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cur_d   = next_code(cur_q, step_q, stop_q);
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pv_d    = (state_d == S_POINT);
    busy_d  = (state_d != S_IDLE);
    abort_d = (state_q == S_IDLE || state_d == S_IDLE) ? 1'b0 : (abort_q | abort);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      skip_q  <= 1'b0;
      pv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      skip_q  <= en_q | rd_q;
      pv_q    <= pv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
    end
  end

  assign point_valid = pv_q;
  assign cur_delay   = cur_q;
  assign delay_value = cur_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign en          = en_q;
  assign read_delay  = rd_q;

endmodule

// File: tb/tb_ds1124_sweep_ctrl.sv
// Bench for ds1124_sweep_ctrl with a behavioural ds1124_driver model and a point scoreboard.
module tb_ds1124_sweep_ctrl;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, point_ack;
  logic [7:0] start_delay, stop_delay, step;
  logic       point_valid, busy, done, error, en, read_delay;
  logic [7:0] cur_delay, delay_value;
  logic       ready, read_valid;
  logic [7:0] current_delay;

  int errors = 0;
  int checks = 0;
  int en_count = 0;
  int rd_count = 0;
  bit proto_bad = 1'b0;
  bit corrupt = 1'b0;
  logic [7:0] exp_q[$];

  ds1124_sweep_ctrl #(.SETTLE_CYCLES(SC), .VERIFY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_delay(start_delay), .stop_delay(stop_delay), .step(step),
    .point_valid(point_valid), .point_ack(point_ack), .cur_delay(cur_delay),
    .busy(busy), .done(done), .error(error), .delay_value(delay_value),
    .en(en), .read_delay(read_delay), .ready(ready),
    .current_delay(current_delay), .read_valid(read_valid)
  );

  always #5 clk = ~clk;

  // Driver model: busy for 3 cycles after a request, echoes the last written code.
  logic [7:0] stored;
  logic [1:0] dcnt;
  logic       rd_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready <= 1'b1; read_valid <= 1'b0; dcnt <= 2'd0; rd_pend <= 1'b0;
      stored <= 8'd0; current_delay <= 8'd0;
    end else begin
      read_valid <= 1'b0;
      if (en || read_delay) begin
        ready   <= 1'b0;
        dcnt    <= 2'd3;
        rd_pend <= read_delay;
        if (en) stored <= delay_value;
      end else if (dcnt != 2'd0) begin
        dcnt <= dcnt - 2'd1;
        if (dcnt == 2'd1) begin
          ready <= 1'b1;
          if (rd_pend) begin
            read_valid    <= 1'b1;
            current_delay <= (corrupt && stored == 8'h32) ? 8'h33 : stored;
            rd_pend       <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (en) begin en_count++; if (!ready) proto_bad = 1'b1; end
      if (read_delay) begin rd_count++; if (!ready) proto_bad = 1'b1; end
    end
  end

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] e, input logic [7:0] st);
    start_delay = s; stop_delay = e; step = st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; abort = 0; point_ack = 0;
    start_delay = 0; stop_delay = 0; step = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({point_valid, busy, done, error, en, read_delay, cur_delay, delay_value} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {point_valid, busy, done, error, en, read_delay, cur_delay, delay_value});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_sweep(input string name, input logic [7:0] s, input logic [7:0] e,
                           input logic [7:0] st, input int npts, input int exp_done,
                           input logic exp_err);
    int c, nx, dones, cyc;
    logic [7:0] want;
    exp_q.delete();
    c = s;
    for (int i = 0; i < npts; i++) begin
      exp_q.push_back(8'(c));
      nx = c + ((st == 8'd0) ? 1 : int'(st));
      if (nx > int'(e)) nx = e;
      c = nx;
    end
    dones = 0; cyc = 0;
    pulse_start(s, e, st);
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b error=%b expected busy=1 error=0", name, busy, error);
    end
    forever begin
      if (done) dones++;
      if (point_valid && !point_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_point: cur_delay=%0d expected none", name, cur_delay);
        end else begin
          want = exp_q.pop_front();
          if (cur_delay !== want || delay_value !== want) begin
            errors++;
            $display("FAIL %s point: cur_delay=%0d delay_value=%0d expected %0d",
                     name, cur_delay, delay_value, want);
          end
        end
        point_ack = 1'b1;
      end else begin
        point_ack = 1'b0;
      end
      if (!busy || cyc > 3000) break;
      @(negedge clk);
      cyc++;
    end
    point_ack = 1'b0;
    checks++;
    if (cyc > 3000) begin errors++; $display("FAIL %s timeout: busy=%b expected 0", name, busy); end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_points: got %0d left expected 0", name, exp_q.size());
    end
    checks++;
    if (dones != exp_done) begin
      errors++; $display("FAIL %s done_count: got %0d expected %0d", name, dones, exp_done);
    end
    checks++;
    if (error !== exp_err || point_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s end_state: error=%b point_valid=%b expected error=%b pv=0",
               name, error, point_valid, exp_err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bad_range();
    int en0;
    en0 = en_count;
    pulse_start(8'd40, 8'd30, 8'd1);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_range: error=%b busy=%b done=%b expected 1 0 0", error, busy, done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || en_count != en0) begin
      errors++;
      $display("FAIL bad_range_quiet: busy=%b en_pulses=%0d expected 0 0", busy, en_count - en0);
    end
  endtask

  task automatic test_abort_settle();
    int cyc;
    cyc = 0;
    pulse_start(8'd100, 8'd110, 8'd5);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL abort_settle_errclr: error=%b expected 0", error); end
    while (!read_valid && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || point_valid !== 1'b0 || done !== 1'b0 || cyc >= 100) begin
      errors++;
      $display("FAIL abort_settle: busy=%b pv=%b done=%b expected 0 0 0", busy, point_valid, done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort_wrwait();
    int cyc, en0, rd0;
    bit saw_pv, saw_done;
    cyc = 0; saw_pv = 0; saw_done = 0;
    en0 = en_count; rd0 = rd_count;
    pulse_start(8'd120, 8'd130, 8'd5);
    while (!en && cyc < 100) begin @(negedge clk); cyc++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_wrwait_hold: busy=%b expected 1", busy);
    end
    while (busy && cyc < 200) begin
      if (point_valid) saw_pv = 1;
      if (done) saw_done = 1;
      @(negedge clk); cyc++;
    end
    if (done) saw_done = 1;
    checks++;
    if (busy !== 1'b0 || en_count - en0 != 1 || rd_count != rd0 || saw_pv || saw_done) begin
      errors++;
      $display("FAIL abort_wrwait: busy=%b en=%0d rd=%0d pv=%b done=%b expected 0 1 0 0 0",
               busy, en_count - en0, rd_count - rd0, saw_pv, saw_done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    cyc = 0;
    pulse_start(8'd200, 8'd210, 8'd5);
    while (!point_valid && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (point_valid !== 1'b1) begin errors++; $display("FAIL reset_mid_reach: pv=%b expected 1", point_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({point_valid, busy, done, error, en, read_delay, cur_delay, delay_value} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid: got %b expected all zero",
               {point_valid, busy, done, error, en, read_delay, cur_delay, delay_value});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || point_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after: busy=%b pv=%b expected 0 0", busy, point_valid);
    end
  endtask

  initial begin
    test_reset();
    run_sweep("basic", 8'd10, 8'd20, 8'd5, 3, 1, 1'b0);
    run_sweep("clamp", 8'd250, 8'd255, 8'd4, 3, 1, 1'b0);
    run_sweep("single", 8'd77, 8'd77, 8'd9, 1, 1, 1'b0);
    corrupt = 1'b1;
    run_sweep("mismatch", 8'h30, 8'h40, 8'd2, 1, 0, 1'b1);
    corrupt = 1'b0;
    test_bad_range();
    test_abort_settle();
    test_abort_wrwait();
    run_sweep("step0", 8'd5, 8'd7, 8'd0, 3, 1, 1'b0);
    test_reset_mid();
    checks++;
    if (proto_bad) begin errors++; $display("FAIL request_rule: request with ready=0 seen=%b expected 0", proto_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
